// File: rtl/z16_pkg.sv
// Shared encodings for the Z16 data-memory arbiter: FSM states, grant IDs,
// default widths and the 2-way round-robin pick function.
package z16_pkg;

    localparam int Z16_AW = 16;
    localparam int Z16_DW = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_HOST = 1'b1;

    // On contention the side that was not granted last wins.
    function automatic logic rr_pick(input logic elig_cpu, input logic elig_host,
                                     input logic last_grant);
        if (elig_cpu && elig_host) begin
            return ~last_grant;
        end
        if (elig_host) begin
            return GNT_HOST;
        end
        return GNT_CPU;
    endfunction

endpackage

// File: rtl/z16_rr_arb2.sv
// Two-way round-robin arbiter: combinational pick plus a registered
// last-grant pointer that moves only when a grant is actually taken.
module z16_rr_arb2
    import z16_pkg::*;
#(
    parameter bit P_HOST_FIRST = 1'b1
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic elig_cpu,
    input  logic elig_host,
    input  logic advance,
    output logic grant,
    output logic grant_valid
);

    logic last_grant_reg;

    always_comb begin
        grant_valid = elig_cpu | elig_host;
        grant       = rr_pick(elig_cpu, elig_host, last_grant_reg);
    end

    // Pointing at the opposite side makes the preferred side win first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant_reg <= P_HOST_FIRST ? GNT_CPU : GNT_HOST;
        end else if (advance && grant_valid) begin
            last_grant_reg <= grant;
        end
    end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Shares the single synchronous-read Z16 data memory port between the CPU
// load/store path and the host loader; one access every three cycles.
module z16_dmem_arbiter
    import z16_pkg::*;
#(
    parameter int P_AW         = Z16_AW,
    parameter int P_DW         = Z16_DW,
    parameter bit P_HOST_FIRST = 1'b1
)
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cpu_req,
    input  logic            i_cpu_wen,
    input  logic [P_AW-1:0] i_cpu_addr,
    input  logic [P_DW-1:0] i_cpu_wdata,
    output logic            o_cpu_ack,
    output logic [P_DW-1:0] o_cpu_rdata,
    input  logic            i_host_req,
    input  logic            i_host_wen,
    input  logic [P_AW-1:0] i_host_addr,
    input  logic [P_DW-1:0] i_host_wdata,
    output logic            o_host_ack,
    output logic [P_DW-1:0] o_host_rdata,
    output logic [P_AW-1:0] o_mem_addr,
    output logic            o_mem_wen,
    output logic [P_DW-1:0] o_mem_wdata,
    input  logic [P_DW-1:0] i_mem_rdata,
    output logic            o_busy
);

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic            gnt_id_reg;
    logic            wen_reg;
    logic [P_AW-1:0] addr_reg;
    logic [P_DW-1:0] wdata_reg;

    logic [1:0]      req_vec;
    logic [1:0]      wen_vec;
    logic [P_AW-1:0] addr_vec  [2];
    logic [P_DW-1:0] wdata_vec [2];
    logic [1:0]      ack_vec;
    logic [P_DW-1:0] rdata_vec [2];
    logic [1:0]      elig;
    logic            grant;
    logic            grant_valid;
    logic            in_idle;

    assign req_vec[GNT_CPU]    = i_cpu_req;
    assign req_vec[GNT_HOST]   = i_host_req;
    assign wen_vec[GNT_CPU]    = i_cpu_wen;
    assign wen_vec[GNT_HOST]   = i_host_wen;
    assign addr_vec[GNT_CPU]   = i_cpu_addr;
    assign addr_vec[GNT_HOST]  = i_host_addr;
    assign wdata_vec[GNT_CPU]  = i_cpu_wdata;
    assign wdata_vec[GNT_HOST] = i_host_wdata;

    // A side whose ack is showing is still lowering req; skip it this cycle.
    assign elig    = req_vec & ~ack_vec;
    assign in_idle = (state_reg == ST_IDLE);

    z16_rr_arb2 #(
        .P_HOST_FIRST (P_HOST_FIRST)
    ) u_rr_arb2 (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .elig_cpu    (elig[GNT_CPU]),
        .elig_host   (elig[GNT_HOST]),
        .advance     (in_idle),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (grant_valid) state_next = ST_ACCESS;
            ST_ACCESS:  state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= ST_IDLE;
            gnt_id_reg <= GNT_CPU;
            wen_reg    <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (in_idle && grant_valid) begin
                gnt_id_reg <= grant;
                wen_reg    <= wen_vec[grant];
                addr_reg   <= addr_vec[grant];
                wdata_reg  <= wdata_vec[grant];
            end
        end
    end

    // Per-requester completion: ack pulse and read-data holding register.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic            capture_hit;
        logic            ack_reg;
        logic [P_DW-1:0] rdata_reg;
        logic            wait_reg;

        assign capture_hit = (state_reg == ST_CAPTURE) && (gnt_id_reg == 1'(gi));

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                ack_reg   <= 1'b0;
                rdata_reg <= '0;
                wait_reg  <= 1'b0;
            end else begin
                ack_reg  <= capture_hit;
                wait_reg <= req_vec[gi] & ~ack_reg;
                if (capture_hit && !wen_reg) begin
                    rdata_reg <= i_mem_rdata;
                end
            end
        end

        assign ack_vec[gi]   = ack_reg;
        assign rdata_vec[gi] = rdata_reg;

        a_req_held: assert property (@(posedge i_clk) disable iff (i_rst)
                                     (wait_reg && !ack_reg) |-> req_vec[gi]);
    end

    assign o_cpu_ack    = ack_vec[GNT_CPU];
    assign o_host_ack   = ack_vec[GNT_HOST];
    assign o_cpu_rdata  = rdata_vec[GNT_CPU];
    assign o_host_rdata = rdata_vec[GNT_HOST];

    // Gating with reset keeps a write from landing in the reset cycle.
    assign o_mem_addr  = addr_reg;
    assign o_mem_wdata = wdata_reg;
    assign o_mem_wen   = (state_reg == ST_ACCESS) & wen_reg & ~i_rst;
    assign o_busy      = ~in_idle;

endmodule
